camera_config_sequencer: RTL
============================

Name: camera_config_sequencer

Overview:
- Reads the OV7670 configuration table from the registered config ROM, one 16-bit entry per address, starting at address 0.
- Each entry is decoded into an SCCB register write, a fixed delay, or end-of-table.
- Writes are handed one at a time to the SCCB master over a valid/ready command handshake, with a done pulse returned on completion.
- Sits between the top-level camera init trigger, the config ROM and the SCCB master.

Parameters:
- DELAY_CYCLES, 250000, i_clk cycles waited on a delay entry (10 ms at 25 MHz); must be >= 1.
- ROM_AW, 8, ROM address width; last address is 2**ROM_AW-1.

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle pulse; begins configuration from address 0
- o_rom_addr  out  ROM_AW  ROM address (registered)
- i_rom_data  in  16  ROM entry; [15:8] register address, [7:0] value; valid 2 edges after o_rom_addr changes
- o_sccb_valid  out  1  write command valid
- i_sccb_ready  in  1  SCCB master can accept a command
- o_sccb_reg  out  8  register address for the write
- o_sccb_data  out  8  register value for the write
- i_sccb_done  in  1  single-cycle pulse; the accepted write has finished on the bus
- o_busy  out  1  sequence in progress
- o_done  out  1  table completed; held until the next i_start

Behaviour:
- Reset (asynchronous, immediate): state IDLE; o_rom_addr=0, o_sccb_valid=0, o_sccb_reg=0, o_sccb_data=0, o_busy=0, o_done=0; delay counter=0.
- All outputs are registered.
- IDLE: on i_start, o_rom_addr<=0, o_busy<=1, o_done<=0, go FETCH.
- FETCH: waits 2 cycles, which is the ROM's 1-cycle registered latency plus address settling. On the 2nd cycle it samples i_rom_data and goes DECODE.
- DECODE: one cycle.
  - Entry 16'hFFFF: go DONE.
  - Entry 16'hFFF0: load counter with DELAY_CYCLES-1, go DELAY.
  - Any other entry: latch o_sccb_reg=data[15:8], o_sccb_data=data[7:0], set o_sccb_valid=1, go CMD.
- CMD: hold o_sccb_valid, o_sccb_reg and o_sccb_data stable until a cycle with i_sccb_ready=1. At that edge the command is accepted: o_sccb_valid<=0, go WAIT_DONE.
- WAIT_DONE: on i_sccb_done, go NEXT. An i_sccb_done seen in any other state is ignored.
- DELAY: decrement the counter each cycle; when counter==0, go NEXT. Total time spent in DELAY is exactly DELAY_CYCLES cycles.
- NEXT:
  - If o_rom_addr == 2**ROM_AW-1, go DONE (no wrap-around; a table without a terminator ends at the last address).
  - Otherwise o_rom_addr<=o_rom_addr+1, go FETCH.
- DONE: o_busy<=0, o_done<=1, return to IDLE. o_done stays 1 in IDLE until the next i_start.
- i_start while o_busy=1 is ignored.
- i_start in IDLE after completion restarts from address 0 and clears o_done in the same edge.
- Register 0x12 = 0x80 (soft reset) gets no special treatment; the table follows it with a delay entry.
- Throughput, write entry: 2 (FETCH) + 1 (DECODE) + handshake cycles + SCCB time + 1 (NEXT).
- Reset asserted mid-write drops o_sccb_valid immediately. The SCCB master shares the same reset.

Decomposition:
- Package camera_cfg_pkg:
  - state enum {IDLE, FETCH, DECODE, CMD, WAIT_DONE, DELAY, NEXT, DONE}
  - CFG_END = 16'hFFFF, CFG_DELAY = 16'hFFF0
  - CFG_ROM_AW = 8
- Sub-module cfg_delay_timer (load, count, zero flag, 32-bit down-counter) is natural. The FSM and address counter stay in the top module.

Test Plan:
All tests use DELAY_CYCLES=8 and a behavioural registered ROM model. The SCCB model asserts ready 0–3 cycles late and pulses done 5 cycles after accept.
1. Table {12_80, FF_F0, 15_00, FF_FF}, i_start -> commands (0x12,0x80) then (0x15,0x00) accepted in order; exactly 8 cycles in DELAY between the first done and the next fetch; o_done=1 and o_busy=0 after address 3; o_rom_addr never exceeds 3.
2. Hold i_sccb_ready=0 for 20 cycles during CMD -> o_sccb_valid, reg and data stay stable for all 20 cycles; exactly one accept; no duplicate command.
3. Table of 256 write entries with no terminator -> 256 commands issued; o_done set after address 255; o_rom_addr stays 255.
4. Table {FF_FF} only -> o_done asserts with zero commands issued; o_sccb_valid never asserts.
5. Pulse i_start during WAIT_DONE -> ignored, sequence unchanged. Pulse i_start after o_done -> o_done clears, fetch restarts at address 0, full sequence repeats.
6. Assert i_rstn=0 while in CMD with valid=1 -> all outputs go to reset values immediately. After release, idle until i_start; a stray i_sccb_done pulse does not advance the FSM.

Source files
------------

// File: rtl/camera_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
// Table entries are {register, value} unless they match one of the two markers.
package camera_cfg_pkg;

  localparam int unsigned CFG_ROM_AW  = 8;
  localparam int unsigned CFG_ENTRY_W = 16;
  localparam int unsigned CFG_TIMER_W = 32;

  localparam logic [CFG_ENTRY_W-1:0] CFG_END   = 16'hFFFF;
  localparam logic [CFG_ENTRY_W-1:0] CFG_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    CMD,
    WAIT_DONE,
    DELAY,
    NEXT,
    DONE
  } cfg_state_e;

  // One SCCB register write, laid out exactly like a table entry
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] value;
  } sccb_cmd_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter used for fixed settle delays between table entries.
// Counts down while enabled and parks at zero.
module cfg_delay_timer
  import camera_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = CFG_TIMER_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count,
  output logic             zero_c
);

  logic [WIDTH-1:0] value;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (count && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero_c = (value == '0);

endmodule

// File: rtl/camera_config_sequencer.sv
// Walks the OV7670 config ROM from address 0 and issues each entry as an SCCB
// write or a fixed delay, stopping at the end marker or the last ROM address.
module camera_config_sequencer
  import camera_cfg_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter int unsigned ROM_AW       = CFG_ROM_AW
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  output logic [ROM_AW-1:0]      o_rom_addr,
  input  logic [CFG_ENTRY_W-1:0] i_rom_data,
  output logic                   o_sccb_valid,
  input  logic                   i_sccb_ready,
  output logic [7:0]             o_sccb_reg,
  output logic [7:0]             o_sccb_data,
  input  logic                   i_sccb_done,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam logic [ROM_AW-1:0]      ADDR_LAST  = '1;
  localparam logic [CFG_TIMER_W-1:0] DELAY_LOAD = CFG_TIMER_W'(DELAY_CYCLES - 1);

  cfg_state_e             state, nxt_state;
  logic                   fetch_wait, nxt_fetch_wait;
  logic [CFG_ENTRY_W-1:0] entry, nxt_entry;
  logic [ROM_AW-1:0]      nxt_addr;
  logic                   nxt_valid, nxt_busy, nxt_done;
  sccb_cmd_t              cmd, nxt_cmd;
  logic                   timer_load, timer_count, timer_zero;

  cfg_delay_timer #(
    .WIDTH(CFG_TIMER_W)
  ) u_delay_timer (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .load      (timer_load),
    .load_value(DELAY_LOAD),
    .count     (timer_count),
    .zero_c    (timer_zero)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state        <= IDLE;
      fetch_wait   <= 1'b0;
      entry        <= '0;
      o_rom_addr   <= '0;
      o_sccb_valid <= 1'b0;
      cmd          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= nxt_state;
      fetch_wait   <= nxt_fetch_wait;
      entry        <= nxt_entry;
      o_rom_addr   <= nxt_addr;
      o_sccb_valid <= nxt_valid;
      cmd          <= nxt_cmd;
      o_busy       <= nxt_busy;
      o_done       <= nxt_done;
    end
  end

  // Sequencing: fetch (2 cycles for the registered ROM), decode, then act on the entry
  always_comb begin
    nxt_state      = state;
    nxt_fetch_wait = fetch_wait;
    nxt_entry      = entry;
    nxt_addr       = o_rom_addr;
    nxt_valid      = o_sccb_valid;
    nxt_cmd        = cmd;
    nxt_busy       = o_busy;
    nxt_done       = o_done;
    timer_load     = 1'b0;
    timer_count    = 1'b0;

    unique case (state)
      IDLE: begin
        if (i_start) begin
          nxt_addr       = '0;
          nxt_busy       = 1'b1;
          nxt_done       = 1'b0;
          nxt_fetch_wait = 1'b0;
          nxt_state      = FETCH;
        end
      end
      FETCH: begin
        if (fetch_wait) begin
          nxt_entry      = i_rom_data;
          nxt_fetch_wait = 1'b0;
          nxt_state      = DECODE;
        end else begin
          nxt_fetch_wait = 1'b1;
        end
      end
      DECODE: begin
        if (entry == CFG_END) begin
          nxt_state = DONE;
        end else if (entry == CFG_DELAY) begin
          timer_load = 1'b1;
          nxt_state  = DELAY;
        end else begin
          nxt_cmd   = sccb_cmd_t'(entry);
          nxt_valid = 1'b1;
          nxt_state = CMD;
        end
      end
      CMD: begin
        if (i_sccb_ready) begin
          nxt_valid = 1'b0;
          nxt_state = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_sccb_done) begin
          nxt_state = NEXT;
        end
      end
      DELAY: begin
        timer_count = 1'b1;
        if (timer_zero) begin
          nxt_state = NEXT;
        end
      end
      NEXT: begin
        // No wrap: a table without a terminator ends at the last address
        if (o_rom_addr == ADDR_LAST) begin
          nxt_state = DONE;
        end else begin
          nxt_addr       = o_rom_addr + ROM_AW'(1);
          nxt_fetch_wait = 1'b0;
          nxt_state      = FETCH;
        end
      end
      DONE: begin
        nxt_busy  = 1'b0;
        nxt_done  = 1'b1;
        nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  assign o_sccb_reg  = cmd.reg_addr;
  assign o_sccb_data = cmd.value;

endmodule
